// File: rtl/bpi_cmd_arbiter.sv
// BPI command arbiter: shares one BPI flash command port
// between auto-load (AL, priority) and user (USR) requesters.
module bpi_cmd_arbiter #(
  parameter logic [7:0]  START_TMO = 8'd16,
  parameter logic [19:0] BUSY_TMO  = 20'd1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AL_ENA,
  input  logic        AL_EXECUTE,
  input  logic [22:0] AL_ADDR,
  input  logic [15:0] AL_CMD_DATA,
  input  logic [1:0]  AL_OP,
  input  logic        USR_EXECUTE,
  input  logic [22:0] USR_ADDR,
  input  logic [15:0] USR_CMD_DATA,
  input  logic [1:0]  USR_OP,
  input  logic        BPI_BUSY,
  input  logic        CLR_STATUS,
  output logic        BPI_EXECUTE,
  output logic [22:0] BPI_ADDR,
  output logic [15:0] BPI_CMD_DATA,
  output logic [1:0]  BPI_OP,
  output logic        AL_BUSY,
  output logic        USR_BUSY,
  output logic        AL_ACK,
  output logic        USR_ACK,
  output logic [1:0]  OWNER,
  output logic [3:0]  STATUS
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WBSY  = 3'd2;
  localparam logic [2:0] S_WIDLE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_AL   = 2'b01;
  localparam logic [1:0] OWN_USR  = 2'b10;

  logic [2:0]  r_state;
  logic [19:0] r_cnt;
  logic        r_al_pend;
  logic [22:0] r_al_addr;
  logic [15:0] r_al_data;
  logic [1:0]  r_al_op;
  logic        r_usr_pend;
  logic [22:0] r_usr_addr;
  logic [15:0] r_usr_data;
  logic [1:0]  r_usr_op;
  logic [22:0] r_bpi_addr;
  logic [15:0] r_bpi_data;
  logic [1:0]  r_bpi_op;
  logic [1:0]  r_owner;
  logic [3:0]  r_status;

  logic        w_idle_ok;
  logic        w_grant_al;
  logic        w_grant_usr;
  logic        w_al_clr;
  logic        w_usr_clr;
  logic        w_al_take;
  logic        w_usr_take;
  logic        w_al_ovr;
  logic        w_usr_ovr;
  logic [19:0] w_cnt_nxt;
  logic        w_start_tmo;
  logic        w_busy_tmo;

  assign w_idle_ok   = (r_state == S_IDLE) && !BPI_BUSY;
  assign w_grant_al  = w_idle_ok && r_al_pend;
  assign w_grant_usr = w_idle_ok && !r_al_pend
                       && r_usr_pend && !AL_ENA;

  assign w_al_clr  = (r_state == S_DONE) && (r_owner == OWN_AL);
  assign w_usr_clr = (r_state == S_DONE) && (r_owner == OWN_USR);

  // a request landing on the clearing cycle is a fresh capture
  assign w_al_take  = AL_EXECUTE && (!r_al_pend || w_al_clr);
  assign w_usr_take = USR_EXECUTE && (!r_usr_pend || w_usr_clr);
  assign w_al_ovr   = AL_EXECUTE && r_al_pend && !w_al_clr;
  assign w_usr_ovr  = USR_EXECUTE && r_usr_pend && !w_usr_clr;

  // timeouts fire as the counter steps onto the limit-1 value
  assign w_cnt_nxt   = r_cnt + 20'd1;
  assign w_start_tmo = (r_state == S_WBSY) && !BPI_BUSY
                       && (w_cnt_nxt == (20'(START_TMO) - 20'd1));
  assign w_busy_tmo  = (r_state == S_WIDLE) && BPI_BUSY
                       && (w_cnt_nxt == (BUSY_TMO - 20'd1));

  // AL request buffer: capture on accepted pulse, drop on completion
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_al_pend <= 1'b0;
      r_al_addr <= '0;
      r_al_data <= '0;
      r_al_op   <= '0;
    end else if (w_al_take) begin
      r_al_pend <= 1'b1;
      r_al_addr <= AL_ADDR;
      r_al_data <= AL_CMD_DATA;
      r_al_op   <= AL_OP;
    end else if (w_al_clr) begin
      r_al_pend <= 1'b0;
    end
  end

  // USR request buffer: capture on accepted pulse, drop on completion
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_usr_pend <= 1'b0;
      r_usr_addr <= '0;
      r_usr_data <= '0;
      r_usr_op   <= '0;
    end else if (w_usr_take) begin
      r_usr_pend <= 1'b1;
      r_usr_addr <= USR_ADDR;
      r_usr_data <= USR_CMD_DATA;
      r_usr_op   <= USR_OP;
    end else if (w_usr_clr) begin
      r_usr_pend <= 1'b0;
    end
  end

  // granted command fields, held until the next grant
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bpi_addr <= '0;
      r_bpi_data <= '0;
      r_bpi_op   <= '0;
    end else if (w_grant_al) begin
      r_bpi_addr <= r_al_addr;
      r_bpi_data <= r_al_data;
      r_bpi_op   <= r_al_op;
    end else if (w_grant_usr) begin
      r_bpi_addr <= r_usr_addr;
      r_bpi_data <= r_usr_data;
      r_bpi_op   <= r_usr_op;
    end
  end

  // command sequencer with start/busy watchdog counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= OWN_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_al) begin
            r_owner <= OWN_AL;
            r_state <= S_ISSUE;
          end else if (w_grant_usr) begin
            r_owner <= OWN_USR;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WBSY;
        end
        S_WBSY: begin
          if (BPI_BUSY) begin
            r_cnt   <= '0;
            r_state <= S_WIDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_start_tmo) r_state <= S_DONE;
          end
        end
        S_WIDLE: begin
          r_cnt <= w_cnt_nxt;
          if (!BPI_BUSY || w_busy_tmo) r_state <= S_DONE;
        end
        S_DONE: begin
          r_owner <= OWN_NONE;
          r_state <= S_IDLE;
        end
        default: begin
          r_owner <= OWN_NONE;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // sticky error flags; a same-cycle event beats the clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_status <= '0;
    end else begin
      r_status <= (CLR_STATUS ? 4'd0 : r_status)
                  | {w_usr_ovr, w_al_ovr, w_busy_tmo, w_start_tmo};
    end
  end

  assign BPI_EXECUTE  = (r_state == S_ISSUE);
  assign BPI_ADDR     = r_bpi_addr;
  assign BPI_CMD_DATA = r_bpi_data;
  assign BPI_OP       = r_bpi_op;
  assign AL_BUSY      = r_al_pend || (r_owner == OWN_AL);
  assign USR_BUSY     = r_usr_pend || (r_owner == OWN_USR);
  assign AL_ACK       = w_al_clr;
  assign USR_ACK      = w_usr_clr;
  assign OWNER        = r_owner;
  assign STATUS       = r_status;

endmodule

// File: doc/bpi_cmd_arbiter.md
# bpi_cmd_arbiter

Shares the single BPI flash command interface between two requesters: the parameter auto-load sequencer (AL) and the user/JTAG command path (USR). It latches one pending command per requester and grants the interface with fixed AL priority, with user commands locked out while auto-load is enabled. It drives one execute pulse per grant and tracks the BPI BUSY handshake with start and completion watchdogs. Sits between the auto-load constant block plus the user command decoder and the BPI interface engine.

## Interface
- START_TMO, 8'd16: max cycles from BPI_EXECUTE until BPI_BUSY must rise.
- BUSY_TMO, 20'd1000000: max cycles BPI_BUSY may stay high per command.
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- AL_ENA  in  1  auto-load in progress; blocks USR grants.
- AL_EXECUTE  in  1  one-cycle AL command request.
- AL_ADDR  in  23  AL flash address.
- AL_CMD_DATA  in  16  AL command/data word.
- AL_OP  in  2  AL operation code.
- USR_EXECUTE  in  1  one-cycle USR command request.
- USR_ADDR  in  23  USR flash address.
- USR_CMD_DATA  in  16  USR command/data word.
- USR_OP  in  2  USR operation code.
- BPI_BUSY  in  1  BPI engine busy.
- CLR_STATUS  in  1  clears sticky STATUS bits.
- BPI_EXECUTE  out  1  one-cycle command strobe to the BPI engine.
- BPI_ADDR  out  23  granted address, registered.
- BPI_CMD_DATA  out  16  granted command/data word, registered.
- BPI_OP  out  2  granted opcode, registered.
- AL_BUSY  out  1  AL request pending or in service.
- USR_BUSY  out  1  USR request pending or in service.
- AL_ACK  out  1  one-cycle completion pulse to AL.
- USR_ACK  out  1  one-cycle completion pulse to USR.
- OWNER  out  2  00 none, 01 AL, 10 USR.
- STATUS  out  4  sticky {usr_ovr, al_ovr, busy_tmo, start_tmo}.

## Operation
- Per-requester buffer: an *_EXECUTE pulse sets *_pend and captures addr/data/op. A pulse while *_pend=1 is ignored, and the matching *_ovr bit sets.
- FSM states: IDLE, ISSUE, WAIT_BSY, WAIT_IDLE, DONE.
- IDLE: requires BPI_BUSY=0 before granting.
  - If al_pend, grant AL.
  - Else if usr_pend and AL_ENA=0, grant USR.
  - On grant: load the BPI_* registers from the winner's buffer, set OWNER, and go to ISSUE.
- ISSUE: BPI_EXECUTE=1, clear the counter, go to WAIT_BSY.
- WAIT_BSY:
  - BPI_BUSY=1: go to WAIT_IDLE and clear the counter.
  - Counter reaches START_TMO-1: set start_tmo and go to DONE.
- WAIT_IDLE:
  - BPI_BUSY=0: go to DONE.
  - Counter reaches BUSY_TMO-1: set busy_tmo and go to DONE.
- DONE: pulse the owner's ACK, clear the owner's pend, set OWNER=00, go to IDLE. Timed-out commands are still acked.
- If a new *_EXECUTE arrives in the same cycle as DONE clears that requester's pend, the new capture wins: pend stays 1, no overrun.
- *_BUSY = *_pend, or OWNER equals that requester.
- CLR_STATUS clears all STATUS bits. An error event in the same cycle wins.
- BPI_ADDR/DATA/OP hold their value from grant until the next grant.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Pends and counter 0.
- Latency, request pulse in cycle 0 with the interface idle:
  - pend=1 in cycle 1.
  - State ISSUE with BPI_EXECUTE=1 and BPI_* valid in cycle 2.
- Best case, BUSY rises in cycle 3 and falls in cycle k: DONE in cycle k+1, ACK=1 in cycle k+1, OWNER=00 and IDLE in cycle k+2.
- Back-to-back: the next grant can issue at the earliest 2 cycles after DONE (IDLE, then ISSUE).
- Simultaneous AL/USR pulses: both latched; AL served first, USR issued after AL's DONE unless AL_ENA=1.
- AL_ENA rising while USR is in service: no preemption. USR completes; further USR grants wait.
- RST mid-command: all state cleared immediately; pending commands are lost and not acked.

## Test plan
- AL pulse with addr 0x780021 and op 10 → BPI_EXECUTE in cycle 2 with BPI_ADDR=0x780021. BUSY high for 5 cycles → one AL_ACK, OWNER back to 00.
- AL and USR pulses in the same cycle, AL_ENA=0 → AL issued first. USR_EXECUTE follows AL_ACK by at least 2 cycles with the USR fields.
- USR pulse with AL_ENA=1 held for 50 cycles → no BPI_EXECUTE. Drop AL_ENA → USR issued in the second cycle after the drop.
- BPI_BUSY never rises (START_TMO=16) → STATUS=0001 and ACK exactly 16 cycles after ISSUE. CLR_STATUS → STATUS=0000.
- Second USR pulse while the first is pending → STATUS[3]=1, and the buffered first command is issued unchanged.
- RST asserted during WAIT_IDLE → all outputs 0 that cycle, no ACK. After release, a new AL request completes normally.
